// File: rtl/jtag_ir_decoder.sv
// jtag_ir_decoder: JTAG IR/DR back end (IR shift/update, BYPASS, IDCODE, TDO mux).
// Optional USERCODE instruction is compiled in when JTAG_USERCODE_EN is defined.
module jtag_ir_decoder #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0A6F,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0001
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tdi,
    input  logic                captureIR,
    input  logic                shiftIR,
    input  logic                updateIR,
    input  logic                captureDR,
    input  logic                shiftDR,
    input  logic                updateDR,
    input  logic                tdo_en,
    input  logic                bsr_tdo,
    output logic [IR_WIDTH-1:0] instr,
    output logic                sel_bypass,
    output logic                sel_idcode,
    output logic                sel_bsr,
`ifdef JTAG_USERCODE_EN
    output logic                sel_usercode,
`endif
    output logic                extest,
    output logic                tdo
);

    localparam logic [IR_WIDTH-1:0] OP_EXTEST   = '0;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);
`ifdef JTAG_USERCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(3);
`else
    localparam logic [31:0] unused_usercode_val = USERCODE_VAL;
`endif

    if (IR_WIDTH < 2 || !IDCODE_VAL[0]) begin : g_param_check
        $error("jtag_ir_decoder: needs IR_WIDTH >= 2 and IDCODE_VAL[0] == 1");
    end

    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_reg;
    logic [31:0]         id_sr;
`ifdef JTAG_USERCODE_EN
    logic [31:0]         uc_sr;
`endif

    // updateDR belongs to the external boundary-scan register
    logic unused_update_dr;
    assign unused_update_dr = updateDR;

    // All unlisted codes, including all-ones, fall through to BYPASS
    always_comb begin
        sel_bypass = 1'b0;
        sel_idcode = 1'b0;
        sel_bsr    = 1'b0;
`ifdef JTAG_USERCODE_EN
        sel_usercode = 1'b0;
`endif
        if (instr == OP_EXTEST || instr == OP_SAMPLE)
            sel_bsr = 1'b1;
        else if (instr == OP_IDCODE)
            sel_idcode = 1'b1;
`ifdef JTAG_USERCODE_EN
        else if (instr == OP_USERCODE)
            sel_usercode = 1'b1;
`endif
        else
            sel_bypass = 1'b1;
    end

    assign extest = (instr == OP_EXTEST);

    always_comb begin
        tdo = 1'b0;
        if (tdo_en) begin
            if (shiftIR) begin
                tdo = ir_sr[0];
            end else begin
                unique case (1'b1)
                    sel_bsr:      tdo = bsr_tdo;
                    sel_idcode:   tdo = id_sr[0];
`ifdef JTAG_USERCODE_EN
                    sel_usercode: tdo = uc_sr[0];
`endif
                    default:      tdo = bypass_reg;
                endcase
            end
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            ir_sr      <= IR_CAPTURE;
            instr      <= OP_IDCODE;
            bypass_reg <= 1'b0;
            id_sr      <= IDCODE_VAL;
`ifdef JTAG_USERCODE_EN
            uc_sr      <= USERCODE_VAL;
`endif
        end else begin
            if (captureIR)
                ir_sr <= IR_CAPTURE;
            else if (shiftIR)
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            else if (updateIR)
                instr <= ir_sr;

            if (sel_bypass) begin
                if (captureDR)
                    bypass_reg <= 1'b0;
                else if (shiftDR)
                    bypass_reg <= tdi;
            end

            if (sel_idcode) begin
                if (captureDR)
                    id_sr <= IDCODE_VAL;
                else if (shiftDR)
                    id_sr <= {tdi, id_sr[31:1]};
            end

`ifdef JTAG_USERCODE_EN
            if (sel_usercode) begin
                if (captureDR)
                    uc_sr <= USERCODE_VAL;
                else if (shiftDR)
                    uc_sr <= {tdi, uc_sr[31:1]};
            end
`endif
        end
    end

endmodule

// File: tb/tb_jtag_ir_decoder.sv
// tb_jtag_ir_decoder: directed + random bench for jtag_ir_decoder.
// Reference model keeps each scan register as a bit queue, LSB at the front.
module tb_jtag_ir_decoder;

    localparam int          IRW = 4;
    localparam logic [31:0] IDV = 32'h1000_0A6F;
    localparam logic [31:0] UCV = 32'h0000_0001;

    localparam int K_BYP = 0;
    localparam int K_ID  = 1;
    localparam int K_BSR = 2;
    localparam int K_UC  = 3;

    logic           tck = 1'b0;
    logic           reset, tdi, tdo_en, bsr_tdo;
    logic           captureIR, shiftIR, updateIR;
    logic           captureDR, shiftDR, updateDR;
    logic [IRW-1:0] instr;
    logic           sel_bypass, sel_idcode, sel_bsr, extest, tdo;
`ifdef JTAG_USERCODE_EN
    logic           sel_usercode;
`endif

    int ncmp  = 0;
    int nfail = 0;

    always #5 tck = ~tck;

    jtag_ir_decoder #(
        .IR_WIDTH    (IRW),
        .IDCODE_VAL  (IDV),
        .USERCODE_VAL(UCV)
    ) dut (
        .tck         (tck),
        .reset       (reset),
        .tdi         (tdi),
        .captureIR   (captureIR),
        .shiftIR     (shiftIR),
        .updateIR    (updateIR),
        .captureDR   (captureDR),
        .shiftDR     (shiftDR),
        .updateDR    (updateDR),
        .tdo_en      (tdo_en),
        .bsr_tdo     (bsr_tdo),
        .instr       (instr),
        .sel_bypass  (sel_bypass),
        .sel_idcode  (sel_idcode),
        .sel_bsr     (sel_bsr),
`ifdef JTAG_USERCODE_EN
        .sel_usercode(sel_usercode),
`endif
        .extest      (extest),
        .tdo         (tdo)
    );

    typedef bit bq_t[$];

    bq_t ir_q, id_q, uc_q;
    bit  m_byp;
    int  m_instr;

    function automatic bq_t to_q(logic [31:0] v, int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[i]);
        return q;
    endfunction

    function automatic int q_val(bq_t q);
        int v = 0;
        for (int i = 0; i < q.size(); i++) v = v | (int'(q[i]) << i);
        return v;
    endfunction

    function automatic int kind(int code);
        if (code == 0 || code == 2) return K_BSR;
        if (code == 1) return K_ID;
`ifdef JTAG_USERCODE_EN
        if (code == 3) return K_UC;
`endif
        return K_BYP;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        ncmp++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        ir_q    = to_q(32'd1, IRW);
        m_instr = 1;
        m_byp   = 1'b0;
        id_q    = to_q(IDV, 32);
        uc_q    = to_q(UCV, 32);
    endtask

    task automatic model_tick(bit rst, bit cir, bit sir, bit uir,
                              bit cdr, bit sdr, bit d);
        int k = kind(m_instr);
        if (rst) begin
            model_reset();
            return;
        end
        if (cir) ir_q = to_q(32'd1, IRW);
        else if (sir) begin
            void'(ir_q.pop_front());
            ir_q.push_back(d);
        end else if (uir) m_instr = q_val(ir_q);
        case (k)
            K_BYP: if (cdr) m_byp = 1'b0; else if (sdr) m_byp = d;
            K_ID: begin
                if (cdr) id_q = to_q(IDV, 32);
                else if (sdr) begin
                    void'(id_q.pop_front());
                    id_q.push_back(d);
                end
            end
            K_UC: begin
                if (cdr) uc_q = to_q(UCV, 32);
                else if (sdr) begin
                    void'(uc_q.pop_front());
                    uc_q.push_back(d);
                end
            end
            default: ;
        endcase
    endtask

    function automatic bit exp_tdo(bit en, bit sir, bit b);
        if (!en) return 1'b0;
        if (sir) return ir_q[0];
        case (kind(m_instr))
            K_BSR:   return b;
            K_ID:    return id_q[0];
            K_UC:    return uc_q[0];
            default: return m_byp;
        endcase
    endfunction

    task automatic check_outputs();
        int k = kind(m_instr);
        chk("instr",      32'(instr),      32'(m_instr));
        chk("sel_bypass", 32'(sel_bypass), 32'(k == K_BYP));
        chk("sel_idcode", 32'(sel_idcode), 32'(k == K_ID));
        chk("sel_bsr",    32'(sel_bsr),    32'(k == K_BSR));
`ifdef JTAG_USERCODE_EN
        chk("sel_usercode", 32'(sel_usercode), 32'(k == K_UC));
`endif
        chk("extest", 32'(extest), 32'(m_instr == 0));
        chk("tdo", 32'(tdo), 32'(exp_tdo(tdo_en, shiftIR, bsr_tdo)));
    endtask

    task automatic step(bit rst, bit cir, bit sir, bit uir, bit cdr,
                        bit sdr, bit udr, bit en, bit d, bit b);
        reset     = rst;
        captureIR = cir;
        shiftIR   = sir;
        updateIR  = uir;
        captureDR = cdr;
        shiftDR   = sdr;
        updateDR  = udr;
        tdo_en    = en;
        tdi       = d;
        bsr_tdo   = b;
        #1;
        check_outputs();
        @(posedge tck);
        model_tick(rst, cir, sir, uir, cdr, sdr, d);
        #1;
    endtask

    task automatic scan_ir(logic [IRW-1:0] code);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < IRW; i++)
            step(0, 0, 1, 0, 0, 0, 0, 1, code[i], 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic scan_dr(int n, logic [31:0] data);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 1, 0, 1, data[i], 1'($urandom_range(0, 1)));
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        captureIR = 1'b0;
        shiftIR   = 1'b0;
        updateIR  = 1'b0;
        captureDR = 1'b0;
        shiftDR   = 1'b0;
        updateDR  = 1'b0;
        tdo_en    = 1'b0;
        tdi       = 1'b0;
        bsr_tdo   = 1'b0;
        @(posedge tck);
        model_reset();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_instr", 32'(instr), 32'h1);
        chk("rst_sel_idcode", 32'(sel_idcode), 32'h1);
        chk("rst_extest", 32'(extest), 32'h0);

        scan_dr(16, 32'($urandom));
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        chk("tdo_en_low", 32'(tdo), 32'h0);
        scan_dr(32, 32'($urandom));

        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < IRW; i++)
            step(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("ir_all_ones", 32'(instr), 32'hF);
        chk("bypass_sel", 32'(sel_bypass), 32'h1);
        scan_dr(8, 32'b0100_1101);

        scan_ir(4'h5);
        chk("op5_instr", 32'(instr), 32'h5);
        chk("op5_bypass", 32'(sel_bypass), 32'h1);
        scan_dr(8, 32'($urandom));

        scan_ir(4'h0);
        chk("extest_sel", 32'(sel_bsr), 32'h1);
        chk("extest_out", 32'(extest), 32'h1);
        scan_dr(12, 32'($urandom));

        scan_ir(4'h2);
        scan_dr(6, 32'($urandom));

        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        chk("midshift_rst", 32'(instr), 32'h1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("upd_after_rst", 32'(instr), 32'h1);
        for (int i = 0; i < IRW; i++)
            step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);

        scan_ir(4'h3);
`ifdef JTAG_USERCODE_EN
        chk("uc_sel", 32'(sel_usercode), 32'h1);
`else
        chk("op3_bypass", 32'(sel_bypass), 32'h1);
`endif
        scan_dr(32, 32'($urandom));

        for (int n = 0; n < 600; n++) begin
            bit r_rst, r_cir, r_sir, r_uir, r_cdr, r_sdr;
            r_rst = ($urandom_range(0, 99) < 2);
            r_cir = ($urandom_range(0, 5) == 0);
            r_sir = ($urandom_range(0, 2) == 0);
            r_uir = ($urandom_range(0, 5) == 0);
            r_cdr = ($urandom_range(0, 7) == 0);
            r_sdr = ($urandom_range(0, 2) == 0);
            step(r_rst, r_cir, r_sir, r_uir, r_cdr, r_sdr,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (n % 50 == 0) begin
                scan_ir(IRW'($urandom));
                scan_dr(int'($urandom_range(1, 33)), 32'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/jtag_ir_decoder.md
Name: jtag_ir_decoder

Overview:
- Instruction-register and data-register back end directly downstream of tap_controller.
- Consumes the TAP state strobes (captureIR/shiftIR/updateIR, captureDR/shiftDR/updateDR, tdo_en) and holds the IR shift stage and IR update latch.
- Decodes the current instruction into data-register selects, owns the BYPASS and IDCODE registers, and muxes TDO.
- Single tck domain; enables replace the gated clockIR/clockDR.

Parameters:
- IR_WIDTH, 4, instruction register width (min 2)
- IDCODE_VAL, 32'h1000_0A6F, value captured by IDCODE; bit 0 must be 1
- USERCODE_VAL, 32'h0000_0001, value captured by USERCODE (used only when the optional feature is compiled in)

Ports:
- tck  in  1  test clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; driven from tap_controller reset (Test-Logic-Reset)
- tdi  in  1  serial data in
- captureIR, shiftIR, updateIR  in  1 each  IR strobes from tap_controller
- captureDR, shiftDR, updateDR  in  1 each  DR strobes from tap_controller
- tdo_en  in  1  shift-state qualifier from tap_controller
- bsr_tdo  in  1  serial out of external boundary-scan register
- instr  out  IR_WIDTH  current (updated) instruction
- sel_bypass, sel_idcode, sel_bsr  out  1 each  one-hot DR select
- extest  out  1  high while instr == EXTEST (pad drive from BSR)
- tdo  out  1  serial data out, 0 when tdo_en low

Behaviour:
- Opcodes: EXTEST = all-zeros, IDCODE = 0..01, SAMPLE_PRELOAD = 0..010, BYPASS = all-ones. Any other code decodes as BYPASS; instr still shows the raw code.
- Reset, synchronous and overriding all strobes, including mid-shift:
  - ir_sr = 0..01, instr = IDCODE.
  - bypass_reg = 0, id_sr = IDCODE_VAL.
  - Selects: sel_idcode = 1, others 0; extest = 0.
- IR priority when several strobes are high in the same cycle: captureIR > shiftIR > updateIR.
  - captureIR: ir_sr <= {0.., 2'b01}.
  - shiftIR: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]} (LSB out first).
  - updateIR: instr <= ir_sr. Decode outputs change the same edge as instr; they are combinational from instr.
- DR strobes act only on the register selected by the current instr; captureDR > shiftDR.
  - BYPASS: captureDR loads 0; shiftDR loads tdi (1-bit delay).
  - IDCODE: captureDR loads IDCODE_VAL; shiftDR shifts right, tdi into bit 31.
  - EXTEST, SAMPLE_PRELOAD: sel_bsr = 1; no internal DR.
  - updateDR: no internal effect; it is consumed by the BSR.
- TDO mux (combinational):
  - shiftIR: ir_sr[0].
  - Otherwise by select: bypass_reg, id_sr[0], or bsr_tdo.
  - Forced 0 when tdo_en = 0.
  - Negedge retiming is done at the pad, not in this block.
- instr is stable through DR scans; it changes only on updateIR or reset.
- Latency: an instruction takes effect the edge after updateIR. The first shifted TDO bit is valid the cycle after capture.

Optional Feature:
- Macro JTAG_USERCODE_EN.
- Defined: opcode 0..011 = USERCODE. Adds sel_usercode out (1) and a 32-bit uc_sr that captures USERCODE_VAL on captureDR and shifts like id_sr. TDO selects uc_sr[0]. Reset value uc_sr = USERCODE_VAL.
- Undefined: 0..011 decodes as BYPASS; no sel_usercode port and no uc_sr.

Test Plan:
- Reset -> instr = 4'h1, sel_idcode = 1. captureDR, then 32 shiftDR cycles -> tdo serial stream = IDCODE_VAL LSB first (1,1,1,1,0,1,1,0,...); tdo = 0 whenever tdo_en = 0.
- captureIR, then shiftIR ×4 with tdi = 1,1,1,1 -> tdo = 1,0,0,0 (capture pattern). updateIR -> instr = 4'hF, sel_bypass = 1.
- BYPASS selected: captureDR, then shiftDR ×8 with tdi = 10110010 -> tdo = 0 followed by the tdi stream delayed by one cycle.
- Load opcode 4'h5 -> sel_bypass = 1, instr = 4'h5. Load 4'h0 -> sel_bsr = 1, extest = 1, tdo follows bsr_tdo.
- Assert reset after 2 of 4 IR shift cycles -> next edge instr = 4'h1, ir_sr = 4'h1. A following updateIR then keeps instr = 4'h1.
- With JTAG_USERCODE_EN: load 4'h3, captureDR, shift 32 -> USERCODE_VAL out LSB first. Without the macro: 4'h3 -> sel_bypass = 1.
